// File: rtl/riscv_m_unit_iter.sv
// riscv_m_unit_iter
// Iterative RV32M/RV64M multiply/divide unit that sits beside the execute ALU.
// Multiplies use a radix-2^MUL_STEP shift-add loop. Divides use a radix-2
// restoring loop. Divide-by-zero and signed overflow are answered at once.
//
// Ports
//   clk          rising-edge clock
//   resetn       synchronous active-low reset; also clears rd
//   valid        instruction and operands are presented this cycle
//   flush        abort any in-flight operation; wins over valid
//   instruction  full 32-bit instruction word (R-type decode)
//   rs1, rs2     XLEN-bit operands
//   wr           register write enable (ready and destination index != 0)
//   rd           registered result; holds until the next result load
//   busy         unit occupied (every state except IDLE); valid is ignored
//   ready        one-cycle result strobe
//
// Handshake: an op is taken on a rising edge with valid=1, busy=0, flush=0,
// resetn=1 and an M-extension decode hit. Nothing is acknowledged on the
// input side, so a core that sees busy=1 must hold or re-present the op.
// The result is reported by a single ready cycle, with wr qualifying the
// register write.
module riscv_m_unit_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic            flush,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            wr,
    output logic [XLEN-1:0] rd,
    output logic            busy,
    output logic            ready
);

    localparam int KM = XLEN / MUL_STEP;
    localparam int KD = XLEN;
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] KM_LAST = CW'(KM - 1);
    localparam logic [CW-1:0] KD_LAST = CW'(KD - 1);

    generate
        if (!((XLEN == 32 || XLEN == 64) &&
              (MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8) &&
              (XLEN % MUL_STEP == 0))) begin : g_bad_params
            $error("riscv_m_unit_iter: illegal XLEN/MUL_STEP combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state;
    logic [2:0]          op;
    logic [4:0]          rd_idx;
    logic                neg_q;    // product / quotient must be negated
    logic                neg_r;    // remainder must be negated (dividend sign)
    logic [2*XLEN-1:0]   acc;      // {high/remainder, low/quotient}
    logic [XLEN-1:0]     opb;      // multiplicand or divisor magnitude
    logic [CW-1:0]       cnt;

    // ---------------- decode ----------------
    logic [2:0]      f3;
    logic            is_m, a_signed, b_signed, neg_a, neg_b;
    logic            div0, ovf, special, accept;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    logic            unused_bits;

    assign f3       = instruction[14:12];
    assign is_m     = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
    // MUL keeps both operands unsigned: the low half does not depend on signedness.
    assign a_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    assign b_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    assign neg_a    = a_signed && rs1[XLEN-1];
    assign neg_b    = b_signed && rs2[XLEN-1];
    assign mag_a    = neg_a ? -rs1 : rs1;
    assign mag_b    = neg_b ? -rs2 : rs2;

    assign div0     = (rs2 == '0);
    assign ovf      = !f3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign special  = f3[2] && (div0 || ovf);
    // f3[1] separates REM/REMU from DIV/DIVU.
    assign special_res = div0 ? (f3[1] ? rs1 : '1) : (f3[1] ? '0 : rs1);

    assign accept      = valid && is_m && (state == S_IDLE);
    assign unused_bits = ^instruction[24:15];

    // ---------------- multiply step ----------------
    // Low half of acc holds the multiplier and shifts out MUL_STEP bits per
    // cycle; the partial product is added into the high half.
    logic [XLEN+MUL_STEP-1:0] pp, mul_sum;
    logic [2*XLEN-1:0]        mul_next;

    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (acc[i]) pp = pp + ({{MUL_STEP{1'b0}}, opb} << i);
        end
    end

    assign mul_sum  = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
    assign mul_next = {mul_sum, acc[XLEN-1:MUL_STEP]};

    // ---------------- divide step ----------------
    logic [XLEN:0]     div_shift, div_trial;
    logic [2*XLEN-1:0] div_next;

    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_trial = div_shift - {1'b0, opb};
    assign div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    // ---------------- sign fix and selection ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = rem_fix;
        case (op)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            wr     <= 1'b0;
            rd     <= '0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            op     <= '0;
            rd_idx <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
        end else if (flush) begin
            // Abort: rd keeps its old value and no strobe follows.
            state <= S_IDLE;
            busy  <= 1'b0;
            ready <= 1'b0;
            wr    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    wr    <= 1'b0;
                    if (accept) begin
                        op     <= f3;
                        rd_idx <= instruction[11:7];
                        neg_q  <= neg_a ^ neg_b;
                        neg_r  <= neg_a;
                        acc    <= {{XLEN{1'b0}}, mag_a};
                        opb    <= mag_b;
                        busy   <= 1'b1;
                        if (special) begin
                            rd    <= special_res;
                            state <= S_DONE;
                            ready <= 1'b1;
                            wr    <= (instruction[11:7] != 5'd0);
                        end else if (f3[2]) begin
                            cnt   <= KD_LAST;
                            state <= S_DIV;
                        end else begin
                            cnt   <= KM_LAST;
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    rd    <= fix_res;
                    state <= S_DONE;
                    ready <= 1'b1;
                    wr    <= (rd_idx != 5'd0);
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    wr    <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    wr    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_m_unit_iter.sv
// Testbench for riscv_m_unit_iter (XLEN=32, MUL_STEP=4).
// Drivers push the expected result, wr and ready cycle into queues when an
// op is issued; a monitor on the falling edge pops and compares on ready.
module tb_riscv_m_unit_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            valid = 1'b0;
    logic            flush = 1'b0;
    logic [31:0]     instruction = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            wr;
    logic [XLEN-1:0] rd;
    logic            busy;
    logic            ready;

    riscv_m_unit_iter #(.XLEN(XLEN), .MUL_STEP(4)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .flush(flush),
        .instruction(instruction), .rs1(rs1), .rs2(rs2),
        .wr(wr), .rd(rd), .busy(busy), .ready(ready)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [XLEN-1:0] exp_q[$];
    logic            exp_wr_q[$];
    int              acc_q[$];   // cycle number of the accept edge
    int              done_q[$];  // cycle number of the first ready cycle
    int              n_vec  = 0;
    int              n_fail = 0;
    logic [XLEN-1:0] last_rd = '0;
    bit              mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        exp_wr_q.delete();
        acc_q.delete();
        done_q.delete();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        int              ia, ib;
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'b0, a}; ub = {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from accept to first ready cycle. Early-out cases go straight to
    // DONE, so their ready is up in the cycle right after the accept edge.
    function automatic int latency(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) return 9;
        if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
        return 33;
    endfunction

    function automatic logic [31:0] enc_m(input logic [2:0] f3, input logic [4:0] idx);
        logic [4:0] s1, s2;
        s1 = 5'($urandom_range(0, 31));
        s2 = 5'($urandom_range(0, 31));
        return {7'b0000001, s2, s1, f3, idx, 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            4: return 32'(0) - 32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] idx);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", t);
            return;
        end
        valid = 1'b1;
        instruction = enc_m(f3, idx);
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        exp_q.push_back(ref_m(f3, a, b));
        exp_wr_q.push_back(idx != 5'd0);
        acc_q.push_back(cyc);
        done_q.push_back(cyc + latency(f3, a, b));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            exp_busy = (acc_q.size() != 0) && (cyc >= acc_q[0]);
            check("busy", busy, exp_busy);
            if (ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_ready: rd=%0h with nothing outstanding (cycle %0d)", rd, cyc);
                end else begin
                    check("rd", rd, exp_q[0]);
                    check("wr", wr, exp_wr_q[0]);
                    check("latency", cyc, done_q[0]);
                    last_rd = exp_q[0];
                    void'(exp_q.pop_front());
                    void'(exp_wr_q.pop_front());
                    void'(acc_q.pop_front());
                    void'(done_q.pop_front());
                end
            end else begin
                check("wr_without_ready", wr, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc_b, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd", rd, 32'h0);
        check("reset_wr", wr, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", ready, 1'b0);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Directed arithmetic vectors
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
        issue(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        issue(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd4);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7);
        issue(3'b101, 32'd100, 32'd7, 5'd8);
        issue(3'b111, 32'd100, 32'd7, 5'd9);
        // Early-out cases
        issue(3'b101, 32'h1234, 32'h0, 5'd10);
        issue(3'b111, 32'h1234, 32'h0, 5'd11);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

        // Flush mid-divide: no strobe, rd untouched, unit reusable
        issue(3'b100, 32'd1000, 32'd3, 5'd14);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        clear_q();
        @(negedge clk);
        check("flush_rd", rd, last_rd);
        repeat (40) @(negedge clk);
        issue(3'b000, 32'd12, 32'd13, 5'd15);

        // Reset mid-divide: same abort, rd cleared
        issue(3'b101, 32'd5000, 32'd9, 5'd16);
        repeat (4) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_q();
        last_rd = '0;
        @(negedge clk);
        check("reset_abort_rd", rd, last_rd);
        repeat (40) @(negedge clk);
        issue(3'b000, 32'd21, 32'd2, 5'd17);

        // Valid held high while busy: second op taken on the first IDLE cycle
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        acc_b = acc_q[$] + 33 + 2;
        @(negedge clk);
        valid = 1'b1;
        instruction = enc_m(3'b000, 5'd0);
        rs1 = 32'd6;
        rs2 = 32'd7;
        exp_q.push_back(ref_m(3'b000, 32'd6, 32'd7));
        exp_wr_q.push_back(1'b0);
        acc_q.push_back(acc_b);
        done_q.push_back(acc_b + 9);
        while (cyc < acc_b) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b0;

        // Flush and valid together: flush wins, nothing accepted
        @(negedge clk);
        while (busy && cyc < acc_b + 100) @(negedge clk);
        valid = 1'b1;
        flush = 1'b1;
        instruction = enc_m(3'b101, 5'd4);
        rs1 = 32'd50;
        rs2 = 32'd5;
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        repeat (5) @(negedge clk);

        // Flush during DONE keeps that cycle's strobe
        issue(3'b101, 32'h55, 32'h0, 5'd7);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) @(negedge clk);

        // Non-M instructions: ADD and an RV64 W-form are never accepted
        @(negedge clk);
        valid = 1'b1;
        instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        repeat (3) @(negedge clk);
        instruction = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0111011};
        repeat (3) @(negedge clk);
        valid = 1'b0;

        // Randomised ops against the reference model
        for (int k = 0; k < 80; k++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  idx;
            f3  = 3'($urandom_range(0, 7));
            a   = rand_op();
            b   = rand_op();
            idx = 5'($urandom_range(0, 31));
            issue(f3, a, b, idx);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Drain
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results never arrived", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
